// File: rtl/mem_stage_if.sv
// mem_stage_if: Execute-to-Memory stage bundle plus the registered values handed on to Writeback/hazard unit.
interface mem_stage_if;
  logic [31:0] Instr_M_In;
  logic [31:0] PC_M_In;
  logic [4:0]  WriteReg_M_In;
  logic        RegWrite_M_In;
  logic [31:0] ALUOut_M_In;
  logic [31:0] WriteData_M_In;
  logic [1:0]  T_new_M_In;
  logic [31:0] Result_M_In;
  logic        Trans_M_In;
  logic [31:0] Instr_M_Out;
  logic [31:0] PC_M_Out;
  logic [4:0]  WriteReg_M_Out;
  logic [4:0]  Rt_M_Out;
  logic        RegWrite_M_Out;
  logic [31:0] ALUOut_M_Out;
  logic [31:0] ReadData_M_Out;
  logic [1:0]  T_new_M_Out;
  modport master (
    output Instr_M_In, PC_M_In, WriteReg_M_In, RegWrite_M_In, ALUOut_M_In,
           WriteData_M_In, T_new_M_In, Result_M_In, Trans_M_In,
    input  Instr_M_Out, PC_M_Out, WriteReg_M_Out, Rt_M_Out, RegWrite_M_Out,
           ALUOut_M_Out, ReadData_M_Out, T_new_M_Out
  );
  modport slave (
    input  Instr_M_In, PC_M_In, WriteReg_M_In, RegWrite_M_In, ALUOut_M_In,
           WriteData_M_In, T_new_M_In, Result_M_In, Trans_M_In,
    output Instr_M_Out, PC_M_Out, WriteReg_M_Out, Rt_M_Out, RegWrite_M_Out,
           ALUOut_M_Out, ReadData_M_Out, T_new_M_Out
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MIPS memory stage -- E/M pipeline register, data memory with byte-enable stores and extending loads.
module mem_stage #(
  parameter int DM_WORDS  = 3072,
  parameter int ADDR_BITS = 12
) (
  input logic clk,
  input logic reset,
  mem_stage_if.slave m
);
  logic [31:0] instr, pc, alu_out, write_data;
  logic [4:0]  write_reg;
  logic        reg_write;
  logic [1:0]  t_new;
  logic [31:0] mem [DM_WORDS];
  // A word reads as zero until first written, which makes reset clear the whole memory.
  logic [DM_WORDS-1:0] valid;
  logic [5:0]  op;
  logic        is_sw, is_sh, is_sb, is_lw, is_lh, is_lhu, is_lb, is_lbu, store, in_range;
  logic [ADDR_BITS-1:0] idx;
  logic [31:0] word, store_data, wdata, merged, shifted;
  logic [3:0]  be;
  logic [15:0] half;
  logic [7:0]  byte_v;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      instr      <= '0;
      pc         <= '0;
      write_reg  <= '0;
      reg_write  <= 1'b0;
      alu_out    <= '0;
      write_data <= '0;
      t_new      <= '0;
      valid      <= '0;
    end else begin
      instr      <= m.Instr_M_In;
      pc         <= m.PC_M_In;
      write_reg  <= m.WriteReg_M_In;
      reg_write  <= m.RegWrite_M_In;
      alu_out    <= m.ALUOut_M_In;
      write_data <= m.WriteData_M_In;
      t_new      <= (m.T_new_M_In == 2'd0) ? 2'd0 : m.T_new_M_In - 2'd1;
      if (store && in_range) valid[idx] <= 1'b1;
    end

  always_ff @(posedge clk)
    if (reset && store && in_range) begin
      mem[idx] <= merged;
      $display("@%h: *%h <= %h", pc, {alu_out[31:2], 2'b00}, merged);
    end

  always_comb begin
    op         = instr[31:26];
    is_sw      = op == 6'b101011;
    is_sh      = op == 6'b101001;
    is_sb      = op == 6'b101000;
    is_lw      = op == 6'b100011;
    is_lh      = op == 6'b100001;
    is_lhu     = op == 6'b100101;
    is_lb      = op == 6'b100000;
    is_lbu     = op == 6'b100100;
    store      = is_sw | is_sh | is_sb;
    idx        = alu_out[ADDR_BITS+1:2];
    in_range   = int'(idx) < DM_WORDS;
    word       = (in_range && valid[idx]) ? mem[idx] : '0;
    store_data = m.Trans_M_In ? m.Result_M_In : write_data;
    be         = is_sw ? 4'b1111 : is_sh ? (alu_out[1] ? 4'b1100 : 4'b0011) : 4'b0001 << alu_out[1:0];
    wdata      = is_sw ? store_data : is_sh ? {2{store_data[15:0]}} : {4{store_data[7:0]}};
    merged     = word;
    for (int i = 0; i < 4; i++) merged[8*i+:8] = be[i] ? wdata[8*i+:8] : word[8*i+:8];
    half       = alu_out[1] ? word[31:16] : word[15:0];
    shifted    = word >> {alu_out[1:0], 3'b000};
    byte_v     = shifted[7:0];
  end

  assign m.ReadData_M_Out = is_lw  ? word :
                            is_lh  ? {{16{half[15]}}, half} :
                            is_lhu ? {16'b0, half} :
                            is_lb  ? {{24{byte_v[7]}}, byte_v} :
                            is_lbu ? {24'b0, byte_v} : '0;
  assign m.Instr_M_Out    = instr;
  assign m.PC_M_Out       = pc;
  assign m.WriteReg_M_Out = write_reg;
  assign m.Rt_M_Out       = instr[20:16];
  assign m.RegWrite_M_Out = reg_write;
  assign m.ALUOut_M_Out   = alu_out;
  assign m.T_new_M_Out    = t_new;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of the memory stage pipeline register, stores, loads and reset behaviour.
module tb_mem_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int passed = 0;
  logic [31:0] pc = 32'h0000_3000;
  localparam logic [5:0] SW = 6'h2b, SH = 6'h29, SB = 6'h28, LW = 6'h23,
                         LH = 6'h21, LHU = 6'h25, LB = 6'h20, LBU = 6'h24, ADDI = 6'h08;

  mem_stage_if bus ();
  mem_stage dut (.clk(clk), .reset(reset), .m(bus.slave));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Present one instruction to the stage and let it enter M.
  task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data);
    pc = pc + 32'd4;
    bus.Instr_M_In     = {op, 5'd1, 5'd2, 16'h0};
    bus.PC_M_In        = pc;
    bus.ALUOut_M_In    = addr;
    bus.WriteData_M_In = data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.Instr_M_In     = 32'hFFFF_FFFF;
    bus.PC_M_In        = 32'h1234_5678;
    bus.WriteReg_M_In  = 5'd31;
    bus.RegWrite_M_In  = 1'b1;
    bus.ALUOut_M_In    = 32'h10;
    bus.WriteData_M_In = 32'hDEAD_BEEF;
    bus.T_new_M_In     = 2'd3;
    bus.Result_M_In    = 32'h0;
    bus.Trans_M_In     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_instr", bus.Instr_M_Out, 32'h0);
    check("rst_pc", bus.PC_M_Out, 32'h0);
    check("rst_wreg", {27'h0, bus.WriteReg_M_Out}, 32'h0);
    check("rst_regwrite", {31'h0, bus.RegWrite_M_Out}, 32'h0);
    check("rst_alu", bus.ALUOut_M_Out, 32'h0);
    check("rst_tnew", {30'h0, bus.T_new_M_Out}, 32'h0);
    check("rst_rdata", bus.ReadData_M_Out, 32'h0);
    reset = 1'b1;
    bus.WriteReg_M_In = 5'd0;
    bus.RegWrite_M_In = 1'b0;
    bus.T_new_M_In    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      issue(LW, 32'(i * 4), 32'h0);
      check($sformatf("rst_dm%0d", i), bus.ReadData_M_Out, 32'h0);
    end

    issue(SW, 32'h10, 32'h1234_5678);
    issue(LW, 32'h10, 32'h0);
    check("sw_lw", bus.ReadData_M_Out, 32'h1234_5678);
    issue(ADDI, 32'h10, 32'h0);
    check("nonload_zero", bus.ReadData_M_Out, 32'h0);

    issue(SW, 32'h20, 32'h0);
    issue(SB, 32'h23, 32'h1111_11AB);
    issue(SH, 32'h20, 32'h2222_BEEF);
    issue(LW, 32'h20, 32'h0);
    check("partial_lw", bus.ReadData_M_Out, 32'hAB00_BEEF);
    issue(LB, 32'h23, 32'h0);
    check("lb_neg", bus.ReadData_M_Out, 32'hFFFF_FFAB);
    issue(LBU, 32'h23, 32'h0);
    check("lbu", bus.ReadData_M_Out, 32'h0000_00AB);
    issue(LH, 32'h20, 32'h0);
    check("lh_neg", bus.ReadData_M_Out, 32'hFFFF_BEEF);
    issue(LHU, 32'h20, 32'h0);
    check("lhu", bus.ReadData_M_Out, 32'h0000_BEEF);
    issue(LH, 32'h22, 32'h0);
    check("lh_upper", bus.ReadData_M_Out, 32'hFFFF_AB00);
    issue(LB, 32'h20, 32'h0);
    check("lb_byte0", bus.ReadData_M_Out, 32'hFFFF_FFEF);
    issue(LBU, 32'h22, 32'h0);
    check("lbu_byte2", bus.ReadData_M_Out, 32'h0000_0000);

    // Store data comes from W at the write edge, not from the captured rt value.
    issue(SW, 32'h40, 32'h1);
    bus.Trans_M_In  = 1'b1;
    bus.Result_M_In = 32'hCAFE_F00D;
    issue(LW, 32'h40, 32'h0);
    bus.Trans_M_In  = 1'b0;
    bus.Result_M_In = 32'h0;
    check("fwd_store", bus.ReadData_M_Out, 32'hCAFE_F00D);

    bus.WriteReg_M_In = 5'd17;
    bus.RegWrite_M_In = 1'b1;
    bus.T_new_M_In    = 2'd2;
    issue(ADDI, 32'hA5A5_0F0F, 32'h0);
    check("tnew_2", {30'h0, bus.T_new_M_Out}, 32'h1);
    check("pass_pc", bus.PC_M_Out, pc);
    check("pass_instr", bus.Instr_M_Out, {ADDI, 5'd1, 5'd2, 16'h0});
    check("pass_wreg", {27'h0, bus.WriteReg_M_Out}, 32'd17);
    check("pass_rt", {27'h0, bus.Rt_M_Out}, 32'd2);
    check("pass_regwrite", {31'h0, bus.RegWrite_M_Out}, 32'h1);
    check("pass_alu", bus.ALUOut_M_Out, 32'hA5A5_0F0F);
    bus.T_new_M_In = 2'd1;
    bus.RegWrite_M_In = 1'b0;
    issue(ADDI, 32'h0, 32'h0);
    check("tnew_1", {30'h0, bus.T_new_M_Out}, 32'h0);
    check("pass_regwrite0", {31'h0, bus.RegWrite_M_Out}, 32'h0);
    bus.T_new_M_In = 2'd0;
    issue(ADDI, 32'h0, 32'h0);
    check("tnew_0", {30'h0, bus.T_new_M_Out}, 32'h0);
    bus.T_new_M_In = 2'd3;
    issue(ADDI, 32'h0, 32'h0);
    check("tnew_3", {30'h0, bus.T_new_M_Out}, 32'h2);
    bus.T_new_M_In    = 2'd0;
    bus.WriteReg_M_In = 5'd0;

    issue(SW, 32'h2FFC, 32'h7777_8888);
    issue(SW, 32'h3000, 32'hDEAD_BEEF);
    issue(LW, 32'h3000, 32'h0);
    check("oor_load", bus.ReadData_M_Out, 32'h0);
    issue(LW, 32'h2FFC, 32'h0);
    check("last_word", bus.ReadData_M_Out, 32'h7777_8888);
    issue(LW, 32'h0, 32'h0);
    check("oor_no_alias", bus.ReadData_M_Out, 32'h0);

    issue(SW, 32'h50, 32'h5555_5555);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_instr", bus.Instr_M_Out, 32'h0);
    check("mid_rst_pc", bus.PC_M_Out, 32'h0);
    check("mid_rst_alu", bus.ALUOut_M_Out, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    issue(LW, 32'h50, 32'h0);
    check("mid_rst_nowrite", bus.ReadData_M_Out, 32'h0);
    issue(LW, 32'h10, 32'h0);
    check("rst_clears_dm", bus.ReadData_M_Out, 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
